// File: rtl/cntr8_cmd_gen_if.sv
// cntr8_cmd_gen_if
//   Bundles the request handshake and the counter command/status signals of
//   cntr8_cmd_gen.
//   Handshake: a request transfers on a rising clk edge where
//   req_valid & req_ready are both 1. req_target is sampled only on that edge.
//   req_valid seen while req_ready=0 is ignored, not queued.
//   Signals:
//     req_valid   requester -> gen   request present
//     req_target  requester -> gen   requested counter value
//     req_ready   gen -> requester   1 only while idle
//     load        gen -> counter     load d_in this edge
//     inc         gen -> counter     1 = +1, 0 = -1 (when load=0)
//     d_in        gen -> counter     load data
//     cur_val     gen -> requester   mirror of the counter value
//     busy        gen -> requester   operation in progress
//     done        gen -> requester   1-cycle arrival pulse
//   Modports: master = requester side, slave = generator side.
interface cntr8_cmd_gen_if #(
  parameter int WIDTH = 8
) ();
  logic             req_valid;
  logic [WIDTH-1:0] req_target;
  logic             req_ready;
  logic             load;
  logic             inc;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] cur_val;
  logic             busy;
  logic             done;

  modport master (
    output req_valid, req_target,
    input  req_ready, load, inc, d_in, cur_val, busy, done
  );

  modport slave (
    input  req_valid, req_target,
    output req_ready, load, inc, d_in, cur_val, busy, done
  );
endinterface

// File: rtl/cntr8_cmd_gen.sv
// cntr8_cmd_gen
//   Drives the load/inc/d_in inputs of an up/down counter so that it reaches a
//   requested target. Short distances (<= LOAD_THRESH) are walked with single
//   inc/dec steps in the shorter direction (tie goes up); longer distances use
//   one direct load. A mirror of the counter value is kept to choose the
//   direction and to detect arrival. All outputs are Moore-decoded.
//   Ports:
//     clk          clock, rising edge
//     reset        synchronous, active-high; shared with the counter
//     bus          cntr8_cmd_gen_if.slave (request port + counter commands)
//     o_dbg_state  current FSM state encoding
module cntr8_cmd_gen #(
  parameter int WIDTH       = 8,
  parameter int LOAD_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  cntr8_cmd_gen_if.slave       bus,
  output logic [2:0]           o_dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STEP_UP = 3'd1,
    STEP_DN = 3'd2,
    JUMP    = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO   = '0;
  localparam logic [WIDTH-1:0] THRESH = LOAD_THRESH[WIDTH-1:0];

  state_t           r_state;
  logic [WIDTH-1:0] r_cur;
  logic [WIDTH-1:0] r_tgt;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_cur_nxt;
  logic [WIDTH-1:0] w_tgt_nxt;

  logic [WIDTH-1:0] w_up;
  logic [WIDTH-1:0] w_dn;
  logic [WIDTH-1:0] w_d;
  logic [WIDTH-1:0] w_cur_inc;
  logic [WIDTH-1:0] w_cur_dec;

  logic             w_load;
  logic             w_inc;
  logic [WIDTH-1:0] w_d_in;
  logic             w_ready;
  logic             w_busy;
  logic             w_done;

  // Modulo-2^WIDTH distances from the mirror to the incoming target.
  assign w_up      = bus.req_target - r_cur;
  assign w_dn      = r_cur - bus.req_target;
  assign w_d       = (w_up <= w_dn) ? w_up : w_dn;
  assign w_cur_inc = r_cur + ONE;
  assign w_cur_dec = r_cur - ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cur   <= '0;
      r_tgt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_tgt   <= w_tgt_nxt;
    end
  end

  // Next state and mirror update. The mirror moves on the same edge as the
  // counter, so it equals the counter value after every edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_tgt_nxt   = r_tgt;
    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_tgt_nxt = bus.req_target;
          if (w_d == ZERO)       w_state_nxt = DONE;
          else if (w_d > THRESH) w_state_nxt = JUMP;
          else if (w_up <= w_dn) w_state_nxt = STEP_UP;
          else                   w_state_nxt = STEP_DN;
        end
      end
      STEP_UP: begin
        w_cur_nxt = w_cur_inc;
        if (w_cur_inc == r_tgt) w_state_nxt = DONE;
      end
      STEP_DN: begin
        w_cur_nxt = w_cur_dec;
        if (w_cur_dec == r_tgt) w_state_nxt = DONE;
      end
      JUMP: begin
        w_cur_nxt   = r_tgt;
        w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Moore outputs. Idle-like states reload the current value so the counter
  // holds still.
  always_comb begin
    w_load  = 1'b1;
    w_inc   = 1'b0;
    w_d_in  = r_cur;
    w_ready = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      IDLE:    w_ready = 1'b1;
      STEP_UP: begin
        w_load = 1'b0;
        w_inc  = 1'b1;
        w_busy = 1'b1;
      end
      STEP_DN: begin
        w_load = 1'b0;
        w_busy = 1'b1;
      end
      JUMP: begin
        w_d_in = r_tgt;
        w_busy = 1'b1;
      end
      DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.load      = w_load;
  assign bus.inc       = w_inc;
  assign bus.d_in      = w_d_in;
  assign bus.cur_val   = r_cur;
  assign bus.req_ready = w_ready;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_cntr8_cmd_gen.sv
module tb_cntr8_cmd_gen;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [7:0] S_IDLE    = 8'd0;
  localparam logic [7:0] S_STEP_UP = 8'd1;
  localparam logic [7:0] S_STEP_DN = 8'd2;
  localparam logic [7:0] S_JUMP    = 8'd3;
  localparam logic [7:0] S_DONE    = 8'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cntr8_cmd_gen_if #(.WIDTH(8)) u_if ();

  cntr8_cmd_gen #(.WIDTH(8), .LOAD_THRESH(4)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (u_if.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full output snapshot: load, inc, d_in, cur_val, ready, busy, done.
  task automatic chk_all(input string tag, input logic ld, input logic in,
                         input logic [7:0] din, input logic [7:0] cur,
                         input logic rdy, input logic bsy, input logic dn);
    chk({tag, ".load"},  {7'd0, u_if.load},      {7'd0, ld});
    chk({tag, ".inc"},   {7'd0, u_if.inc},       {7'd0, in});
    chk({tag, ".d_in"},  u_if.d_in,              din);
    chk({tag, ".cur"},   u_if.cur_val,           cur);
    chk({tag, ".ready"}, {7'd0, u_if.req_ready}, {7'd0, rdy});
    chk({tag, ".busy"},  {7'd0, u_if.busy},      {7'd0, bsy});
    chk({tag, ".done"},  {7'd0, u_if.done},      {7'd0, dn});
  endtask

  // Step-cycle snapshot (d_in not meaningful while stepping).
  task automatic chk_step(input string tag, input logic in, input logic [7:0] cur);
    chk({tag, ".load"}, {7'd0, u_if.load}, 8'd0);
    chk({tag, ".inc"},  {7'd0, u_if.inc},  {7'd0, in});
    chk({tag, ".cur"},  u_if.cur_val,      cur);
    chk({tag, ".busy"}, {7'd0, u_if.busy}, 8'd1);
    chk({tag, ".done"}, {7'd0, u_if.done}, 8'd0);
  endtask

  // ---------------- driver ----------------
  // Presents one request for exactly one rising edge; returns on the negedge
  // after the accept edge.
  task automatic send(input logic [7:0] t);
    @(negedge clk);
    u_if.req_valid  = 1'b1;
    u_if.req_target = t;
    @(negedge clk);
    u_if.req_valid  = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    u_if.req_valid  = 1'b0;
    u_if.req_target = 8'h00;
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1: reset state
    chk_all("rst", 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("rst.state", {5'd0, dbg_state}, S_IDLE);
    reset = 1'b0;

    // 2: 0x00 -> 0x03, three up steps
    send(8'h03);
    chk("up.state", {5'd0, dbg_state}, S_STEP_UP);
    chk_step("up0", 1'b1, 8'h00);
    @(negedge clk); chk_step("up1", 1'b1, 8'h01);
    @(negedge clk); chk_step("up2", 1'b1, 8'h02);
    @(negedge clk); chk_all("up_done", 1'b1, 1'b0, 8'h03, 8'h03, 1'b0, 1'b1, 1'b1);
    @(negedge clk); chk_all("up_idle", 1'b1, 1'b0, 8'h03, 8'h03, 1'b1, 1'b0, 1'b0);

    // 3: 0x03 -> 0x01, two down steps
    send(8'h01);
    chk("dn.state", {5'd0, dbg_state}, S_STEP_DN);
    chk_step("dn0", 1'b0, 8'h03);
    @(negedge clk); chk_step("dn1", 1'b0, 8'h02);
    @(negedge clk); chk_all("dn_done", 1'b1, 1'b0, 8'h01, 8'h01, 1'b0, 1'b1, 1'b1);
    @(negedge clk); chk("dn_idle.ready", {7'd0, u_if.req_ready}, 8'd1);

    // Return to 0 via reset for the wrap case
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    chk("rst2.cur", u_if.cur_val, 8'h00);

    // 4: 0x00 -> 0xFE, down through the wrap
    send(8'hFE);
    chk("wrap.state", {5'd0, dbg_state}, S_STEP_DN);
    chk_step("wrap0", 1'b0, 8'h00);
    @(negedge clk); chk_step("wrap1", 1'b0, 8'hFF);
    @(negedge clk); chk_all("wrap_done", 1'b1, 1'b0, 8'hFE, 8'hFE, 1'b0, 1'b1, 1'b1);
    @(negedge clk); chk("wrap_idle.ready", {7'd0, u_if.req_ready}, 8'd1);

    // 5: 0xFE -> 0x80, distance 0x7E uses one load
    send(8'h80);
    chk("jump.state", {5'd0, dbg_state}, S_JUMP);
    chk_all("jump", 1'b1, 1'b0, 8'h80, 8'hFE, 1'b0, 1'b1, 1'b0);
    @(negedge clk); chk_all("jump_done", 1'b1, 1'b0, 8'h80, 8'h80, 1'b0, 1'b1, 1'b1);
    @(negedge clk); chk("jump_idle.ready", {7'd0, u_if.req_ready}, 8'd1);

    // Equal target: done right after accept
    send(8'h80);
    chk("eq.state", {5'd0, dbg_state}, S_DONE);
    chk_all("eq_done", 1'b1, 1'b0, 8'h80, 8'h80, 1'b0, 1'b1, 1'b1);
    @(negedge clk); chk_all("eq_idle", 1'b1, 1'b0, 8'h80, 8'h80, 1'b1, 1'b0, 1'b0);

    // Threshold boundary: distance 5 loads, distance 4 steps
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    send(8'h05);
    chk("thr5.state", {5'd0, dbg_state}, S_JUMP);
    chk("thr5.d_in", u_if.d_in, 8'h05);
    @(negedge clk); chk("thr5_done.cur", u_if.cur_val, 8'h05);
    chk("thr5_done.done", {7'd0, u_if.done}, 8'd1);

    // req_valid held while busy is ignored (0x05 -> 0x03 steps down)
    send(8'h03);
    u_if.req_valid  = 1'b1;
    u_if.req_target = 8'h55;
    chk_step("ign0", 1'b0, 8'h05);
    @(negedge clk); chk_step("ign1", 1'b0, 8'h04);
    @(negedge clk); chk_all("ign_done", 1'b1, 1'b0, 8'h03, 8'h03, 1'b0, 1'b1, 1'b1);
    u_if.req_valid = 1'b0;
    @(negedge clk); chk_all("ign_idle", 1'b1, 1'b0, 8'h03, 8'h03, 1'b1, 1'b0, 1'b0);
    @(negedge clk); chk("ign_hold.cur", u_if.cur_val, 8'h03);

    // 6: reset in STEP_UP at cur 0x02 (0 -> 4, distance 4 still steps)
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    send(8'h04);
    chk("thr4.state", {5'd0, dbg_state}, S_STEP_UP);
    chk_step("rs0", 1'b1, 8'h00);
    @(negedge clk); chk_step("rs1", 1'b1, 8'h01);
    @(negedge clk); chk_step("rs2", 1'b1, 8'h02);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_all("rs_idle", 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("rs_idle.state", {5'd0, dbg_state}, S_IDLE);
    repeat (4) begin
      @(negedge clk);
      chk("rs_nodone", {7'd0, u_if.done}, 8'd0);
    end
    chk("rs_final.cur", u_if.cur_val, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
